// File: rtl/csa_accumulate_ctrl.sv
// Carry-save multi-operand accumulator with a one-cycle resolve stage.
// Define CSA_ACC_SIGNED_EN for two's-complement operands and result.
module csa_accumulate_ctrl #(
  parameter  int WIDTH        = 8,
  parameter  int MAX_OPERANDS = 8,
  localparam int CNT_W        = $clog2(MAX_OPERANDS + 1),
  localparam int ACC_WIDTH    = WIDTH + $clog2(MAX_OPERANDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CNT_W-1:0]     op_count,
  output logic                 busy,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e               state_q;
  logic [ACC_WIDTH-1:0] sum_q;
  logic [ACC_WIDTH-1:0] cy_q;
  logic [ACC_WIDTH-1:0] res_q;
  logic [CNT_W-1:0]     rem_q;

  logic [ACC_WIDTH-1:0] x;
  logic [ACC_WIDTH-1:0] maj;
  logic [ACC_WIDTH-1:0] sum_d;
  logic [ACC_WIDTH-1:0] cy_d;
  logic [CNT_W-1:0]     rem_d;
  logic                 beat;

  // Operand extension, one 3:2 compression and job-length clamp.
  always_comb begin
`ifdef CSA_ACC_SIGNED_EN
    x = ACC_WIDTH'($signed(in_data));
`else
    x = ACC_WIDTH'(in_data);
`endif
    sum_d = sum_q ^ cy_q ^ x;
    maj   = (sum_q & cy_q) | (sum_q & x) | (cy_q & x);
    cy_d  = maj << 1;
    if (op_count > CNT_W'(MAX_OPERANDS)) begin
      rem_d = CNT_W'(MAX_OPERANDS);
    end else begin
      rem_d = op_count;
    end
  end

  assign beat      = in_valid && (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;

  // Job sequencer: redundant accumulation, resolve, then hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      cy_q    <= '0;
      res_q   <= '0;
      rem_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sum_q <= '0;
            cy_q  <= '0;
            if (op_count == '0) begin
              res_q   <= '0;
              rem_q   <= '0;
              state_q <= DONE;
            end else begin
              rem_q   <= rem_d;
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (beat) begin
            sum_q <= sum_d;
            cy_q  <= cy_d;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          res_q   <= sum_q + cy_q;
          state_q <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulate_ctrl.sv
// Directed bench for csa_accumulate_ctrl (WIDTH=8, MAX_OPERANDS=8).
// Expected sums are hand-computed constants.
module tb_csa_accumulate_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op_count;
  logic        busy;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] result;
  logic        out_valid;
  logic        out_ready;

  int checks;
  int errors;
  logic [7:0] vec [16];

  csa_accumulate_ctrl #(
    .WIDTH(8),
    .MAX_OPERANDS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op_count(op_count),
    .busy(busy),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .result(result),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int cnt);
    start    = 1'b1;
    op_count = 4'(cnt);
    tick();
    start    = 1'b0;
  endtask

  task automatic run_job(input string tag, input int cnt, input bit gaps,
                         input bit poke, input int exp_beats,
                         input logic [31:0] exp_res);
    int acc;
    int g;
    do_start(cnt);
    acc = 0;
    g   = 0;
    while (in_ready && g < 100) begin
      in_valid = gaps ? (g % 2 == 1) : 1'b1;
      in_data  = vec[acc];
      start    = poke && (acc == 1);
      op_count = 4'd1;
      if (in_valid) acc++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({tag, "_beats"}, acc, exp_beats);
    g = 0;
    while (!out_valid && g < 10) begin
      tick();
      g++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_res"}, result, exp_res);
    out_ready = 1'b1;
    start     = poke;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    op_count  = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_res", result, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic 3-operand job with exact timing
    vec[0] = 8'd5; vec[1] = 8'd7; vec[2] = 8'd9;
    do_start(3);
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = vec[i];
      chk("t1_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_rdy_lo", in_ready, 0);
    chk("t1_resolve_nv", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_res", result, 21);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_hold_v", out_valid, 1);
      chk("t4_hold_r", result, 21);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_idle", busy, 0);
    chk("t1_nv", out_valid, 0);

    // zero-operand job
    do_start(0);
    chk("t3_valid", out_valid, 1);
    chk("t3_ready", in_ready, 0);
    chk("t3_res", result, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_idle", busy, 0);

    // full width, no truncation
    for (int i = 0; i < 8; i++) vec[i] = 8'hFF;
    run_job("t2", 8, 1'b0, 1'b0, 8, 32'h7F8);

    // bubbles give the same answer
    vec[0] = 8'd10; vec[1] = 8'd20; vec[2] = 8'd30; vec[3] = 8'd40;
    run_job("t4_nogap", 4, 1'b0, 1'b0, 4, 100);
    run_job("t4_gap", 4, 1'b1, 1'b0, 4, 100);

    // stray starts in ACCUM and DONE
    vec[0] = 8'd1; vec[1] = 8'd2; vec[2] = 8'd3;
    run_job("t5_poke", 3, 1'b0, 1'b1, 3, 6);

    // clamp to MAX_OPERANDS
    for (int i = 0; i < 12; i++) vec[i] = 8'(i + 1);
    run_job("t5_clamp", 12, 1'b0, 1'b0, 8, 36);

    // asynchronous abort mid-job
    do_start(4);
    in_valid = 1'b1;
    in_data  = 8'd50;
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_ready", in_ready, 0);
    chk("t6_valid", out_valid, 0);
    chk("t6_res", result, 0);
    tick();
    rst_n = 1'b1;
    tick();
    vec[0] = 8'd3; vec[1] = 8'd4;
    run_job("t6_job", 2, 1'b0, 1'b0, 2, 7);

    // -3 + 1
    vec[0] = 8'hFD; vec[1] = 8'h01;
`ifdef CSA_ACC_SIGNED_EN
    run_job("t6_sgn", 2, 1'b0, 1'b0, 2, 32'h7FE);
`else
    run_job("t6_sgn", 2, 1'b0, 1'b0, 2, 32'h0FE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
